// File: rtl/bit_timing_gen.sv
// Sub-bit / bit-time / phase timing generator with HALT, free-RUN and single-STEP control.
// Every output comes straight from a flop so downstream gating sees glitch-free lines.
module bit_timing_gen #(
    parameter int SUBS   = 4,
    parameter int BITS   = 14,
    parameter int PHASES = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        run,
    input  logic                                        step_req,
    output logic                                        step_ack,
    output logic [SUBS-1:0]                             sub,
    output logic [BITS-1:0]                             bt,
    output logic [PHASES-1:0]                           ph,
    output logic [((BITS > 1) ? $clog2(BITS) : 1)-1:0]     bt_num,
    output logic [((PHASES > 1) ? $clog2(PHASES) : 1)-1:0] ph_num,
    output logic                                        cyc_end,
    output logic                                        halted
);

    localparam int SW = (SUBS > 1) ? $clog2(SUBS) : 1;
    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(SUBS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(PHASES - 1);

    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     subIdx_q, subIdx_d;
    logic [BW-1:0]     btIdx_q, btIdx_d;
    logic [PW-1:0]     phIdx_q, phIdx_d;
    logic [SUBS-1:0]   sub_q, sub_d;
    logic [BITS-1:0]   bt_q, bt_d;
    logic [PHASES-1:0] ph_q, ph_d;
    logic              stepPrev_q;
    logic              stepAck_q, stepAck_d;
    logic              cycEnd_q, cycEnd_d;
    logic              halted_q, halted_d;
    logic              stepEdge;

    // Next state and counters; the registered cycEnd_q marks the final clk of a cycle.
    always_comb begin
        state_d   = state_q;
        subIdx_d  = subIdx_q;
        btIdx_d   = btIdx_q;
        phIdx_d   = phIdx_q;
        stepAck_d = 1'b0;
        stepEdge  = step_req & ~stepPrev_q;

        case (state_q)
            HALT: begin
                subIdx_d = '0;
                btIdx_d  = '0;
                phIdx_d  = '0;
                if (run) begin
                    state_d = RUN;
                end else if (stepEdge) begin
                    state_d = STEP;
                end
            end
            RUN, STEP: begin
                if (cycEnd_q) begin
                    stepAck_d = (state_q == STEP);
                    state_d   = run ? RUN : HALT;
                    subIdx_d  = '0;
                    btIdx_d   = '0;
                    phIdx_d   = '0;
                end else if (subIdx_q != SUB_LAST) begin
                    subIdx_d = subIdx_q + SW'(1);
                end else begin
                    subIdx_d = '0;
                    if (btIdx_q != BIT_LAST) begin
                        btIdx_d = btIdx_q + BW'(1);
                    end else begin
                        btIdx_d = '0;
                        phIdx_d = phIdx_q + PW'(1);
                    end
                end
            end
            default: state_d = HALT;
        endcase

        // Line decode is done on next-state values so the outputs themselves are pure flops.
        halted_d = (state_d == HALT);
        sub_d    = halted_d ? '0 : (SUBS'(1) << subIdx_d);
        bt_d     = BITS'(1) << btIdx_d;
        ph_d     = PHASES'(1) << phIdx_d;
        cycEnd_d = !halted_d && (subIdx_d == SUB_LAST) && (btIdx_d == BIT_LAST)
                   && (phIdx_d == PH_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HALT;
            subIdx_q   <= '0;
            btIdx_q    <= '0;
            phIdx_q    <= '0;
            sub_q      <= '0;
            bt_q       <= BITS'(1);
            ph_q       <= PHASES'(1);
            stepPrev_q <= 1'b0;
            stepAck_q  <= 1'b0;
            cycEnd_q   <= 1'b0;
            halted_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            subIdx_q   <= subIdx_d;
            btIdx_q    <= btIdx_d;
            phIdx_q    <= phIdx_d;
            sub_q      <= sub_d;
            bt_q       <= bt_d;
            ph_q       <= ph_d;
            stepPrev_q <= step_req;
            stepAck_q  <= stepAck_d;
            cycEnd_q   <= cycEnd_d;
            halted_q   <= halted_d;
        end
    end

    assign step_ack = stepAck_q;
    assign sub      = sub_q;
    assign bt       = bt_q;
    assign ph       = ph_q;
    assign bt_num   = btIdx_q;
    assign ph_num   = phIdx_q;
    assign cyc_end  = cycEnd_q;
    assign halted   = halted_q;

endmodule
